// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
//   Shared types and constants for the RV32I multicycle control path.
//   Contents:
//     state_t      - controller FSM states (also exported on state_o)
//     OPC_*        - major opcode values, shared with immediate generator
//                    and datapath
//     alu_op_t     - ALU operation encoding driven on alu_op
//     *_sel_t      - datapath mux select encodings
//     helpers      - opcode support check, branch funct3 check
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  // Controller states, encoding visible on the state_o debug port
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // Major opcodes (IR[6:0]) of the supported subset
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Branch funct3 values the controller implements
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BGE = 3'b101;

  // ALU operation encoding
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // ALU operand A source
  typedef enum logic [1:0] {
    ASEL_RS1   = 2'd0,
    ASEL_OLDPC = 2'd1,
    ASEL_ZERO  = 2'd2
  } alu_a_sel_t;

  // ALU operand B source
  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } alu_b_sel_t;

  // Memory address source
  typedef enum logic {
    ADDR_PC  = 1'b0,
    ADDR_ALU = 1'b1
  } addr_sel_t;

  // Next-PC source
  typedef enum logic {
    PCSRC_PLUS4  = 1'b0,
    PCSRC_BRANCH = 1'b1
  } pc_src_t;

  // Register file write data source
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MDR = 1'b1
  } wb_sel_t;

  // True for opcodes the controller can sequence past DECODE
  function automatic logic isSupported(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH: ok = 1'b1;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the branch conditions the controller implements
  function automatic logic isBranchF3Ok(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BGE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//   Combinational mapping of {opcode, funct3, funct7_5} to the ALU operation.
//   Ports:
//     i_opcode  [6:0]  IR[6:0]
//     i_funct3  [2:0]  IR[14:12]
//     i_funct75        IR[30]
//     o_aluOp   [3:0]  selected ALU operation (alu_op_t)
// ---------------------------------------------------------------------------
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct75,
  output alu_op_t    o_aluOp
);

  logic w_isOp;
  logic w_isAluFmt;

  assign w_isOp     = (i_opcode == OPC_OP);
  assign w_isAluFmt = w_isOp || (i_opcode == OPC_OPIMM);

  // Loads, stores, LUI and AUIPC all compute base + offset, branches compare
  // by subtraction. Only register-register ADD/SUB looks at IR[30]; for
  // OP-IMM that bit belongs to the immediate except on the shift-right form.
  always_comb begin
    o_aluOp = ALU_ADD;
    if (w_isAluFmt) begin
      case (i_funct3)
        3'b000:  o_aluOp = (w_isOp && i_funct75) ? ALU_SUB : ALU_ADD;
        3'b001:  o_aluOp = ALU_SLL;
        3'b010:  o_aluOp = ALU_SLT;
        3'b011:  o_aluOp = ALU_SLTU;
        3'b100:  o_aluOp = ALU_XOR;
        3'b101:  o_aluOp = i_funct75 ? ALU_SRA : ALU_SRL;
        3'b110:  o_aluOp = ALU_OR;
        default: o_aluOp = ALU_AND;
      endcase
    end else if (i_opcode == OPC_BRANCH) begin
      o_aluOp = ALU_SUB;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control FSM for the RV32I micro datapath. Sequences
//   FETCH/DECODE/EXEC/MEM/WB per instruction and drives every datapath
//   select and enable.
//   Parameter:
//     MEM_TIMEOUT  cycles to wait for mem_ready before trapping (0 = never)
//   Ports:
//     CLK, RST_n                       clock, async active-low reset
//     opcode, funct3, funct7_5         instruction fields from IR
//     zero, lt                         ALU flags for branch resolution
//     mem_ready                        memory completes request this cycle
//     mem_req, mem_we, addr_sel        memory port control
//     ir_we, pc_we, pc_src             fetch / PC update control
//     alu_a_sel, alu_b_sel, alu_op     ALU operand and operation control
//     reg_we, wb_sel, mdr_we           writeback control
//     illegal                          sticky trap indication
//     state_o                          current state_t for observability
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [3:0] alu_op,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       mdr_we,
  output logic       illegal,
  output logic [2:0] state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_waitCnt;

  alu_op_t    w_decAluOp;
  logic       w_timeoutHit;
  logic       w_taken;
  logic       w_memReq;
  logic       w_memWe;
  addr_sel_t  w_addrSel;
  logic       w_irWe;
  logic       w_pcWe;
  pc_src_t    w_pcSrc;
  alu_a_sel_t w_aSel;
  alu_b_sel_t w_bSel;
  alu_op_t    w_aluOp;
  logic       w_regWe;
  wb_sel_t    w_wbSel;
  logic       w_mdrWe;
  logic       w_illegal;

  alu_decoder u_aluDec (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .i_funct75 (funct7_5),
    .o_aluOp   (w_decAluOp)
  );

  // The wait counter holds the number of already-elapsed waiting cycles, so
  // the last allowed waiting cycle is the one where it reads MEM_TIMEOUT-1.
  assign w_timeoutHit = (MEM_TIMEOUT != 0) &&
                        (r_waitCnt == CNT_W'(MEM_TIMEOUT - 1));

  // Branch condition; unsupported funct3 never takes and traps instead
  always_comb begin
    case (funct3)
      F3_BEQ:  w_taken = zero;
      F3_BNE:  w_taken = ~zero;
      F3_BGE:  w_taken = ~lt;
      default: w_taken = 1'b0;
    endcase
  end

  // State register and memory wait counter. The counter only advances while
  // a request is outstanding and unanswered; every other path clears it, so
  // a state change or a completed access always starts a fresh budget.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= FETCH;
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= '0;
      case (r_state)
        FETCH: begin
          if (mem_ready)          r_state <= DECODE;
          else if (w_timeoutHit)  r_state <= TRAP;
          else                    r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
        DECODE: begin
          r_state <= isSupported(opcode) ? EXEC : TRAP;
        end
        EXEC: begin
          case (opcode)
            OPC_LOAD, OPC_STORE:                   r_state <= MEM;
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: r_state <= WB;
            OPC_BRANCH: r_state <= isBranchF3Ok(funct3) ? FETCH : TRAP;
            default:                               r_state <= TRAP;
          endcase
        end
        MEM: begin
          if (mem_ready)          r_state <= (opcode == OPC_LOAD) ? WB : FETCH;
          else if (w_timeoutHit)  r_state <= TRAP;
          else                    r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= TRAP;
      endcase
    end
  end

  // Output decode from state, opcode and mem_ready. EXEC, MEM and WB all
  // present the same ALU operands: MEM needs the address stable while the
  // access is pending, and WB writes the live ALU result back.
  always_comb begin
    w_memReq  = 1'b0;
    w_memWe   = 1'b0;
    w_addrSel = ADDR_PC;
    w_irWe    = 1'b0;
    w_pcWe    = 1'b0;
    w_pcSrc   = PCSRC_PLUS4;
    w_aSel    = ASEL_RS1;
    w_bSel    = BSEL_RS2;
    w_aluOp   = ALU_ADD;
    w_regWe   = 1'b0;
    w_wbSel   = WB_ALU;
    w_mdrWe   = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      FETCH: begin
        w_memReq = 1'b1;
        if (mem_ready) begin
          w_irWe = 1'b1;
          w_pcWe = 1'b1;
        end
      end
      EXEC, MEM, WB: begin
        w_aluOp = w_decAluOp;
        case (opcode)
          OPC_OPIMM, OPC_LOAD, OPC_STORE: w_bSel = BSEL_IMM;
          OPC_LUI: begin
            w_aSel = ASEL_ZERO;
            w_bSel = BSEL_IMM;
          end
          OPC_AUIPC: begin
            w_aSel = ASEL_OLDPC;
            w_bSel = BSEL_IMM;
          end
          default: ;
        endcase
        if (r_state == EXEC && opcode == OPC_BRANCH) begin
          w_pcSrc = PCSRC_BRANCH;
          w_pcWe  = w_taken;
        end
        if (r_state == MEM) begin
          w_memReq  = 1'b1;
          w_addrSel = ADDR_ALU;
          w_memWe   = (opcode == OPC_STORE);
          w_mdrWe   = mem_ready && (opcode == OPC_LOAD);
        end
        if (r_state == WB) begin
          w_regWe = 1'b1;
          w_wbSel = (opcode == OPC_LOAD) ? WB_MDR : WB_ALU;
        end
      end
      TRAP:    w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every output directly so an in-flight request is withdrawn
  // the moment RST_n falls, not at the next clock edge.
  assign mem_req   = RST_n & w_memReq;
  assign mem_we    = RST_n & w_memWe;
  assign addr_sel  = RST_n & w_addrSel;
  assign ir_we     = RST_n & w_irWe;
  assign pc_we     = RST_n & w_pcWe;
  assign pc_src    = RST_n & w_pcSrc;
  assign alu_a_sel = RST_n ? w_aSel : 2'b00;
  assign alu_b_sel = RST_n & w_bSel;
  assign alu_op    = RST_n ? w_aluOp : 4'b0000;
  assign reg_we    = RST_n & w_regWe;
  assign wb_sel    = RST_n & w_wbSel;
  assign mdr_we    = RST_n & w_mdrWe;
  assign illegal   = RST_n & w_illegal;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Cycle-by-cycle check of multicycle_ctrl. Each vector holds the inputs
//   for one cycle and the full expected output word; expectations are queued
//   when the inputs are driven and compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       memReq;
    logic       memWe;
    logic       addrSel;
    logic       irWe;
    logic       pcWe;
    logic       pcSrc;
    logic [1:0] aSel;
    logic       bSel;
    logic [3:0] aluOp;
    logic       regWe;
    logic       wbSel;
    logic       mdrWe;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       lt;
    logic       rdy;
    exp_t       e;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
  logic [1:0] alu_a_sel;
  logic       alu_b_sel;
  logic [3:0] alu_op;
  logic       reg_we, wb_sel, mdr_we, illegal;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  exp_t  expQ[$];
  string tagQ[$];
  vec_t  tbl[$];
  string tblTag[$];

  exp_t F_GO, F_WAIT, DEC, TRP, RST0;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .mdr_we(mdr_we), .illegal(illegal), .state_o(state_o)
  );

  // Builds an expected word; memPc = {req,we,addrSel,irWe,pcWe,pcSrc},
  // tail = {regWe,wbSel,mdrWe,illegal}
  function automatic exp_t mk(input state_t st, input logic [5:0] memPc,
                              input logic [1:0] a, input logic b,
                              input alu_op_t op, input logic [3:0] tail);
    exp_t e;
    e.st = st;
    {e.memReq, e.memWe, e.addrSel, e.irWe, e.pcWe, e.pcSrc} = memPc;
    e.aSel  = a;
    e.bSel  = b;
    e.aluOp = op;
    {e.regWe, e.wbSel, e.mdrWe, e.ill} = tail;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic l,
                                 input logic rdy, input exp_t e);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = l; v.rdy = rdy;
    v.e = e;
    return v;
  endfunction

  function automatic exp_t sampleDut();
    exp_t g;
    g.st = state_o; g.memReq = mem_req; g.memWe = mem_we;
    g.addrSel = addr_sel; g.irWe = ir_we; g.pcWe = pc_we; g.pcSrc = pc_src;
    g.aSel = alu_a_sel; g.bSel = alu_b_sel; g.aluOp = alu_op;
    g.regWe = reg_we; g.wbSel = wb_sel; g.mdrWe = mdr_we; g.ill = illegal;
    return g;
  endfunction

  task automatic row(input string tag, input logic [6:0] opc,
                     input logic [2:0] f3, input logic f7, input logic z,
                     input logic l, input logic rdy, input exp_t e);
    tbl.push_back(mkVec(opc, f3, f7, z, l, rdy, e));
    tblTag.push_back(tag);
  endtask

  // Drive one cycle of inputs and queue what the DUT must show for it
  task automatic applyStimulus(input string tag, input vec_t v);
    opcode    = v.opc;
    funct3    = v.f3;
    funct7_5  = v.f7;
    zero      = v.z;
    lt        = v.lt;
    mem_ready = v.rdy;
    expQ.push_back(v.e);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t  want, got;
    string tag;
    total = total + 1;
    if (expQ.size() == 0) begin
      bad = bad + 1;
      $display("[TB] FAIL scoreboard: no expectation queued");
      return;
    end
    want = expQ.pop_front();
    tag  = tagQ.pop_front();
    got  = sampleDut();
    if (got !== want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s @%0t: got st=%0d word=%05h, want st=%0d word=%05h",
               tag, $time, got.st, got, want.st, want);
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(tag, v);
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string tag, input logic [6:0] opc,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic l, input logic rdy, input exp_t e);
    runVec(tag, mkVec(opc, f3, f7, z, l, rdy, e));
  endtask

  // Synchronous-phase reset pulse: assert just after an edge, check, release
  task automatic resetDut(input string tag);
    RST_n = 1'b0;
    applyStimulus(tag, mkVec(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, RST0));
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  initial begin
    F_GO   = mk(FETCH,  6'b100110, 2'd0, 1'b0, ALU_ADD, 4'b0000);
    F_WAIT = mk(FETCH,  6'b100000, 2'd0, 1'b0, ALU_ADD, 4'b0000);
    DEC    = mk(DECODE, 6'b000000, 2'd0, 1'b0, ALU_ADD, 4'b0000);
    TRP    = mk(TRAP,   6'b000000, 2'd0, 1'b0, ALU_ADD, 4'b0001);
    RST0   = mk(FETCH,  6'b000000, 2'd0, 1'b0, ALU_ADD, 4'b0000);

    // ADDI x1,x0,5: F,D,E,W with reg_we only in the fourth cycle
    row("addi", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("addi", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("addi", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("addi", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b1, ALU_ADD, 4'b1000));
    // SUB: register operands, IR[30] selects subtract
    row("sub",  OPC_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, F_GO);
    row("sub",  OPC_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, DEC);
    row("sub",  OPC_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    row("sub",  OPC_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b0, ALU_SUB, 4'b1000));
    // ADDI with IR[30]=1 stays ADD
    row("addi7", OPC_OPIMM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, F_GO);
    row("addi7", OPC_OPIMM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, DEC);
    row("addi7", OPC_OPIMM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("addi7", OPC_OPIMM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b1, ALU_ADD, 4'b1000));
    // SRAI and SLTU
    row("srai", OPC_OPIMM, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, F_GO);
    row("srai", OPC_OPIMM, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, DEC);
    row("srai", OPC_OPIMM, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_SRA, 4'b0000));
    row("srai", OPC_OPIMM, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b1, ALU_SRA, 4'b1000));
    row("sltu", OPC_OP, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("sltu", OPC_OP, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("sltu", OPC_OP, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b0, ALU_SLTU, 4'b0000));
    row("sltu", OPC_OP, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b0, ALU_SLTU, 4'b1000));
    // LUI (a=zero) and AUIPC (a=OldPC)
    row("lui",  OPC_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("lui",  OPC_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("lui",  OPC_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd2, 1'b1, ALU_ADD, 4'b0000));
    row("lui",  OPC_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd2, 1'b1, ALU_ADD, 4'b1000));
    row("auipc", OPC_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("auipc", OPC_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("auipc", OPC_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd1, 1'b1, ALU_ADD, 4'b0000));
    row("auipc", OPC_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd1, 1'b1, ALU_ADD, 4'b1000));
    // LW zero-wait: 5 cycles
    row("lw0",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("lw0",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("lw0",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0,      2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("lw0",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(MEM,  6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0010));
    row("lw0",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0,      2'd0, 1'b1, ALU_ADD, 4'b1100));
    // LW with 3 wait cycles in MEM: 8 cycles
    row("lw3",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("lw3",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("lw3",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    for (int i = 0; i < 3; i++)
      row("lw3-wait", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, 6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("lw3",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(MEM, 6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0010));
    row("lw3",  OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,  6'b0,      2'd0, 1'b1, ALU_ADD, 4'b1100));
    // LW waiting 3 in FETCH and 3 in MEM: budget restarts per request
    for (int i = 0; i < 3; i++)
      row("lwff-fwait", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, F_WAIT);
    row("lwff", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("lwff", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("lwff", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    for (int i = 0; i < 3; i++)
      row("lwff-mwait", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, 6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("lwff", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(MEM, 6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0010));
    row("lwff", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,  6'b0,      2'd0, 1'b1, ALU_ADD, 4'b1100));
    // SW with 2 wait cycles in MEM, then straight back to FETCH
    row("sw",   OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("sw",   OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("sw",   OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("sw-wait", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, 6'b111000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("sw-wait", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, 6'b111000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    row("sw",   OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(MEM, 6'b111000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    // Branches: {opcode,funct3,zero,lt} -> taken?
    row("beq-t", OPC_BRANCH, F3_BEQ, 1'b0, 1'b1, 1'b0, 1'b1, F_GO);
    row("beq-t", OPC_BRANCH, F3_BEQ, 1'b0, 1'b1, 1'b0, 1'b1, DEC);
    row("beq-t", OPC_BRANCH, F3_BEQ, 1'b0, 1'b1, 1'b0, 1'b1, mk(EXEC, 6'b000011, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    row("beq-n", OPC_BRANCH, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("beq-n", OPC_BRANCH, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("beq-n", OPC_BRANCH, F3_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b000001, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    row("bne-n", OPC_BRANCH, F3_BNE, 1'b0, 1'b1, 1'b0, 1'b1, F_GO);
    row("bne-n", OPC_BRANCH, F3_BNE, 1'b0, 1'b1, 1'b0, 1'b1, DEC);
    row("bne-n", OPC_BRANCH, F3_BNE, 1'b0, 1'b1, 1'b0, 1'b1, mk(EXEC, 6'b000001, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    row("bge-t", OPC_BRANCH, F3_BGE, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    row("bge-t", OPC_BRANCH, F3_BGE, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    row("bge-t", OPC_BRANCH, F3_BGE, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b000011, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    row("bge-n", OPC_BRANCH, F3_BGE, 1'b0, 1'b1, 1'b1, 1'b1, F_GO);
    row("bge-n", OPC_BRANCH, F3_BGE, 1'b0, 1'b1, 1'b1, 1'b1, DEC);
    row("bge-n", OPC_BRANCH, F3_BGE, 1'b0, 1'b1, 1'b1, 1'b1, mk(EXEC, 6'b000001, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    // Back in FETCH after the last branch
    row("post-br", OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_WAIT);

    $display("[TB] start, %0d table vectors", tbl.size());
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0;
    mem_ready = 1'b0;
    RST_n = 1'b1;
    #1 RST_n = 1'b0;
    @(posedge CLK);
    #1;
    resetDut("reset");

    for (int i = 0; i < tbl.size(); i++)
      runVec(tblTag[i], tbl[i]);

    // Unsupported opcode: TRAP after DECODE, sticky, then cleared by reset
    step("ill", 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    step("ill", 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    step("ill-trap", 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, TRP);
    step("ill-trap", OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, TRP);
    step("ill-trap", OPC_LOAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, TRP);
    resetDut("ill-reset");

    // Branch with unsupported funct3 traps from EXEC
    step("bad-br", OPC_BRANCH, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, F_GO);
    step("bad-br", OPC_BRANCH, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, DEC);
    step("bad-br", OPC_BRANCH, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, mk(EXEC, 6'b000001, 2'd0, 1'b0, ALU_SUB, 4'b0000));
    step("bad-br-trap", OPC_BRANCH, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, TRP);
    resetDut("bad-br-reset");

    // Fetch timeout: 4 waiting cycles, never ir_we, then TRAP
    for (int i = 0; i < 4; i++)
      step("fto-wait", OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_WAIT);
    step("fto-trap", OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, TRP);
    step("fto-trap", OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, TRP);
    resetDut("fto-reset");

    // Memory-phase timeout on a load
    step("mto", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    step("mto", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    step("mto", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    for (int i = 0; i < 4; i++)
      step("mto-wait", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, 6'b101000, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    step("mto-trap", OPC_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, TRP);
    resetDut("mto-reset");

    // Reset asserted mid-MEM of a store drops the request immediately
    step("swr", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    step("swr", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    step("swr", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    applyStimulus("swr-mem", mkVec(OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0,
                                   mk(MEM, 6'b111000, 2'd0, 1'b1, ALU_ADD, 4'b0000)));
    @(negedge CLK);
    checkOutput();
    #2 RST_n = 1'b0;
    #1;
    applyStimulus("swr-async", mkVec(OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, RST0));
    checkOutput();
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    step("swr-refetch", OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, F_WAIT);
    step("swr-refetch", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, F_GO);
    step("swr-next", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEC);
    step("swr-next", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(EXEC, 6'b0, 2'd0, 1'b1, ALU_ADD, 4'b0000));
    step("swr-next", OPC_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(WB,   6'b0, 2'd0, 1'b1, ALU_ADD, 4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
